arb_32by4_rr: RTL



---
 rtl/arb_pkg.sv | 18 +
 rtl/mux_32by2_1.sv | 23 ++
 rtl/rr_pick4.sv | 23 ++
 rtl/arb_32by4_rr.sv | 106 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the 4-requester round-robin arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned ARB_DATA_W = 32;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   typedef logic [1:0] src_idx_t;

   // Contents of the one-entry output slot.
   typedef struct packed {
      logic [ARB_DATA_W-1:0] data;
      src_idx_t              src;
      logic                  last;
   } out_beat_t;

endpackage

// File: rtl/mux_32by2_1.sv
// 32-bit 4:1 mux with a 2-bit select.
module mux_32by2_1 #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [DATA_W-1:0] d3,
   input  logic [1:0]        sel,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd1:    y = d1;
         2'd2:    y = d2;
         2'd3:    y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set bit of req scanning ptr, ptr+1, ... mod 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  src_idx_t           ptr,
   output src_idx_t           grant_idx,
   output logic               any
);

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      grant_idx = ptr;
      any       = 1'b0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req[ptr + src_idx_t'(i)]) begin
            grant_idx = ptr + src_idx_t'(i);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_32by4_rr.sv
// Round-robin arbiter/sequencer sharing one 32-bit channel among four requesters,
// with burst locking, a beat-count cap, and a registered one-entry output slot.
module arb_32by4_rr
   import arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req_valid,
   input  logic [3:0]         req_last,
   input  logic [DATA_W-1:0]  req_data0,
   input  logic [DATA_W-1:0]  req_data1,
   input  logic [DATA_W-1:0]  req_data2,
   input  logic [DATA_W-1:0]  req_data3,
   output logic [3:0]         req_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [1:0]         out_src,
   output logic               out_last,
   input  logic               out_ready,
   output logic [1:0]         mux_sel
);

   localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

   arb_state_t        state;
   src_idx_t          rr_ptr;
   src_idx_t          owner;
   logic [CNT_W-1:0]  beat_cnt;
   out_beat_t         slot;

   src_idx_t          pick_idx;
   logic              pick_any;
   logic [DATA_W-1:0] mux_y;
   logic              slot_free;
   logic              accept;
   logic              forced;
   logic              burst_end;

   rr_pick4 u_pick (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   mux_32by2_1 #(.DATA_W(DATA_W)) u_mux (
      .d0  (req_data0),
      .d1  (req_data1),
      .d2  (req_data2),
      .d3  (req_data3),
      .sel (mux_sel),
      .y   (mux_y)
   );

   // Grant selection; with no valid request the picker falls back to rr_ptr.
   always_comb begin
      slot_free = ~out_valid | out_ready;
      req_ready = '0;
      mux_sel   = pick_idx;
      if (state == LOCKED) begin
         mux_sel          = owner;
         req_ready[owner] = slot_free;
      end else if (pick_any) begin
         req_ready[pick_idx] = slot_free;
      end
      accept    = |(req_valid & req_ready);
      forced    = (beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BEATS);
      burst_end = req_last[mux_sel] | forced;
   end

   // Arbitration state and output slot; a load wins over a simultaneous drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         slot      <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         slot.data <= ARB_DATA_W'(mux_y);
         slot.src  <= mux_sel;
         slot.last <= burst_end;
         if (burst_end) begin
            state    <= IDLE;
            rr_ptr   <= mux_sel + src_idx_t'(1);
            beat_cnt <= '0;
         end else begin
            state    <= LOCKED;
            owner    <= mux_sel;
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_data = DATA_W'(slot.data);
   assign out_src  = slot.src;
   assign out_last = slot.last;

endmodule
